// File: rtl/muldiv_unit.sv
// Multi-cycle radix-2 multiply/divide unit with integrated Hi/Lo result registers.
// The operation runs for WIDTH iterations and then spends one fix-up cycle applying the result signs.
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             Start,
   input  logic [1:0]       Op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             HiWe,
   input  logic             LoWe,
   input  logic [WIDTH-1:0] WData,
   output logic             Busy,
   output logic             Done,
   output logic             DivByZero,
   output logic [WIDTH-1:0] Hi,
   output logic [WIDTH-1:0] Lo
);
   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd2;

   logic [1:0]         state;
   logic [CW-1:0]      cnt;
   logic               is_div, neg_q, neg_r, b_zero;
   logic [WIDTH-1:0]   mag_a, mag_b;
   logic [2*WIDTH-1:0] acc;

   // Operand decode at Start. Op[0] selects unsigned and Op[1] selects divide.
   logic             a_neg, b_neg;
   logic [WIDTH-1:0] a_mag, b_mag;
   assign a_neg = ~Op[0] & A[WIDTH-1];
   assign b_neg = ~Op[0] & B[WIDTH-1];
   assign a_mag = a_neg ? -A : A;
   assign b_mag = b_neg ? -B : B;

   // Multiply step: acc = {partial product, remaining multiplier bits}.
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next;
   assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mag_a};
   assign mul_next = acc[0] ? {mul_sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};

   // Divide step: acc = {partial remainder, dividend bits shifting into quotient bits}.
   logic [WIDTH:0]     div_sh, div_diff;
   logic [2*WIDTH-1:0] div_next;
   assign div_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
   assign div_diff = div_sh - {1'b0, mag_b};
   assign div_next = div_diff[WIDTH] ? {div_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                     : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo, rem, fix_hi, fix_lo;
   assign prod_fix = neg_q ? -acc : acc;
   assign quo      = acc[WIDTH-1:0];
   assign rem      = acc[2*WIDTH-1:WIDTH];

   always_comb begin
      fix_hi = prod_fix[2*WIDTH-1:WIDTH];
      fix_lo = prod_fix[WIDTH-1:0];
      if (is_div) begin
         // neg_r holds sign(A), so the divide-by-zero Hi is the original dividend.
         if (b_zero) begin
            fix_hi = neg_r ? -mag_a : mag_a;
            fix_lo = '1;
         end else begin
            fix_hi = neg_r ? -rem : rem;
            fix_lo = neg_q ? -quo : quo;
         end
      end
   end

   assign Busy = (state != S_IDLE);

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state     <= S_IDLE;
         cnt       <= '0;
         is_div    <= 1'b0;
         neg_q     <= 1'b0;
         neg_r     <= 1'b0;
         b_zero    <= 1'b0;
         mag_a     <= '0;
         mag_b     <= '0;
         acc       <= '0;
         Done      <= 1'b0;
         DivByZero <= 1'b0;
         Hi        <= '0;
         Lo        <= '0;
      end else begin
         Done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (Start) begin
                  is_div <= Op[1];
                  mag_a  <= a_mag;
                  mag_b  <= b_mag;
                  neg_q  <= a_neg ^ b_neg;
                  neg_r  <= a_neg;
                  b_zero <= (B == '0);
                  acc    <= Op[1] ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
                  cnt    <= '0;
                  state  <= S_RUN;
               end else begin
                  if (HiWe) Hi <= WData;
                  if (LoWe) Lo <= WData;
               end
            end
            S_RUN: begin
               acc <= is_div ? div_next : mul_next;
               cnt <= cnt + 1'b1;
               if (cnt == CW'(WIDTH - 1)) state <= S_FIX;
            end
            S_FIX: begin
               Hi        <= fix_hi;
               Lo        <= fix_lo;
               DivByZero <= is_div & b_zero;
               Done      <= 1'b1;
               state     <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and randomized bench for muldiv_unit.
// Expected results are queued when an operation starts and compared when Done appears.
module tb_muldiv_unit;
   localparam int W = 32;

   logic         Clk = 1'b0;
   logic         Rst, Start, HiWe, LoWe;
   logic [1:0]   Op;
   logic [W-1:0] A, B, WData;
   logic         Busy, Done, DivByZero;
   logic [W-1:0] Hi, Lo;

   muldiv_unit #(.WIDTH(W)) dut (
      .Clk(Clk), .Rst(Rst), .Start(Start), .Op(Op), .A(A), .B(B),
      .HiWe(HiWe), .LoWe(LoWe), .WData(WData),
      .Busy(Busy), .Done(Done), .DivByZero(DivByZero), .Hi(Hi), .Lo(Lo)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic         dbz;
   } exp_t;
   exp_t sb[$];

   int errors = 0;
   int checks = 0;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input logic [W-1:0] hi, input logic [W-1:0] lo, input logic dbz);
      exp_t e;
      e.hi = hi; e.lo = lo; e.dbz = dbz;
      sb.push_back(e);
   endtask

   // Reference model built on wide signed arithmetic.
   function automatic void model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] hi, output logic [W-1:0] lo, output logic dbz);
      logic signed [2*W-1:0] sa, sbv, p, q, r;
      sa  = op[0] ? {{W{1'b0}}, a} : {{W{a[W-1]}}, a};
      sbv = op[0] ? {{W{1'b0}}, b} : {{W{b[W-1]}}, b};
      dbz = 1'b0;
      if (!op[1]) begin
         p  = sa * sbv;
         hi = p[2*W-1:W];
         lo = p[W-1:0];
      end else if (b == '0) begin
         hi  = a;
         lo  = '1;
         dbz = 1'b1;
      end else begin
         q  = sa / sbv;
         r  = sa % sbv;
         hi = r[W-1:0];
         lo = q[W-1:0];
      end
   endfunction

   // poke: cycle in which Start and HiWe are re-asserted during Busy (0 = none).
   // we_start: assert HiWe alongside the accepted Start.
   task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int poke, input bit we_start, input string tag);
      exp_t         e;
      int           n;
      bit           busy_ok;
      logic [W-1:0] hi_before, lo_before;
      @(negedge Clk);
      hi_before = Hi;
      lo_before = Lo;
      Start = 1'b1; Op = op; A = a; B = b;
      if (we_start) begin HiWe = 1'b1; WData = 32'h5555; end
      @(negedge Clk);
      Start = 1'b0; HiWe = 1'b0;
      Op = 2'($urandom); A = $urandom; B = $urandom;
      busy_ok = 1'b1;
      n = 1;
      while (n <= W + 4) begin
         if (Busy !== (n <= W + 1)) busy_ok = 1'b0;
         if (Done === 1'b1) break;
         if (n == W + 1) begin
            chk({tag, " hi_held"}, Hi, hi_before);
            chk({tag, " lo_held"}, Lo, lo_before);
         end
         if (poke > 0 && n == poke) begin
            Start = 1'b1; HiWe = 1'b1; WData = 32'h1234;
         end else if (poke > 0 && n == poke + 1) begin
            Start = 1'b0; HiWe = 1'b0;
         end
         @(negedge Clk);
         n++;
      end
      chk({tag, " latency"}, n, W + 2);
      chk({tag, " busy"}, busy_ok, 1);
      if (sb.size() == 0) begin
         chk({tag, " scoreboard_empty"}, 1, 0);
      end else begin
         e = sb.pop_front();
         chk({tag, " hi"}, Hi, e.hi);
         chk({tag, " lo"}, Lo, e.lo);
         chk({tag, " dbz"}, DivByZero, e.dbz);
      end
      @(negedge Clk);
      chk({tag, " done_single"}, Done, 0);
      chk({tag, " idle_after"}, Busy, 0);
   endtask

   initial begin
      logic [1:0]   rop;
      logic [W-1:0] ra, rb, ehi, elo;
      logic         edbz;
      bit           done_seen;

      Rst = 1'b1; Start = 1'b0; HiWe = 1'b0; LoWe = 1'b0;
      Op = 2'd0; A = '0; B = '0; WData = '0;
      repeat (2) @(negedge Clk);
      chk("reset busy", Busy, 0);
      chk("reset done", Done, 0);
      chk("reset dbz", DivByZero, 0);
      chk("reset hi", Hi, 0);
      chk("reset lo", Lo, 0);
      Rst = 1'b0;

      push_exp(32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
      run_op(2'd0, 32'hFFFFFFFD, 32'd7, 0, 1'b0, "mult_neg3x7");
      push_exp(32'hFFFFFFFE, 32'h00000001, 1'b0);
      run_op(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1'b0, "multu_max");
      push_exp(32'h0, 32'h1, 1'b0);
      run_op(2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1'b0, "mult_m1xm1");
      push_exp(32'd2, 32'd14, 1'b0);
      run_op(2'd3, 32'd100, 32'd7, 0, 1'b0, "divu_100_7");
      push_exp(32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
      run_op(2'd2, 32'hFFFFFFF9, 32'd2, 0, 1'b0, "div_neg7_2");
      push_exp(32'h0, 32'h80000000, 1'b0);
      run_op(2'd2, 32'h80000000, 32'hFFFFFFFF, 0, 1'b0, "div_min_m1");
      push_exp(32'd5, 32'hFFFFFFFF, 1'b1);
      run_op(2'd2, 32'd5, 32'd0, 0, 1'b0, "div_by_zero");
      push_exp(32'd0, 32'd3, 1'b0);
      run_op(2'd3, 32'd9, 32'd3, 0, 1'b0, "divu_clear_flag");
      push_exp(32'd0, 32'd42, 1'b0);
      run_op(2'd0, 32'd6, 32'd7, 10, 1'b0, "mult_poke_busy");

      // MTHI alone, then MTHI+MTLO together, from IDLE
      @(negedge Clk); HiWe = 1'b1; WData = 32'h1234;
      @(negedge Clk); HiWe = 1'b0;
      chk("mthi hi", Hi, 32'h1234);
      chk("mthi lo_kept", Lo, 32'd42);
      HiWe = 1'b1; LoWe = 1'b1; WData = 32'hABCD;
      @(negedge Clk); HiWe = 1'b0; LoWe = 1'b0;
      chk("mthilo hi", Hi, 32'hABCD);
      chk("mthilo lo", Lo, 32'hABCD);

      push_exp(32'd0, 32'd6, 1'b0);
      run_op(2'd1, 32'd2, 32'd3, 0, 1'b1, "start_beats_we");

      for (int i = 0; i < 8; i++) begin
         rop = 2'(i);
         ra  = $urandom;
         rb  = (i == 6) ? 32'd0 : ((i % 2) ? 32'($urandom_range(1, 50)) : $urandom);
         model(rop, ra, rb, ehi, elo, edbz);
         push_exp(ehi, elo, edbz);
         run_op(rop, ra, rb, 0, 1'b0, $sformatf("rand%0d", i));
      end

      // Reset in the middle of a DIVU
      @(negedge Clk); Start = 1'b1; Op = 2'd3; A = 32'd1000; B = 32'd3;
      @(negedge Clk); Start = 1'b0;
      repeat (14) @(negedge Clk);
      Rst = 1'b1;
      @(negedge Clk); Rst = 1'b0;
      chk("abort busy", Busy, 0);
      chk("abort hi", Hi, 0);
      chk("abort lo", Lo, 0);
      chk("abort dbz", DivByZero, 0);
      done_seen = 1'b0;
      repeat (25) begin
         if (Done === 1'b1) done_seen = 1'b1;
         @(negedge Clk);
      end
      chk("abort no_done", done_seen, 0);

      // Start held together with Rst is overridden
      Rst = 1'b1; Start = 1'b1; Op = 2'd0; A = 32'd3; B = 32'd4;
      @(negedge Clk); Rst = 1'b0; Start = 1'b0;
      chk("rst_start busy", Busy, 0);
      push_exp(32'd0, 32'd12, 1'b0);
      run_op(2'd0, 32'd3, 32'd4, 0, 1'b0, "after_rst_start");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
